// File: rtl/addsub_accumulator_if.sv
// Operation request / result handshake bundle for addsub_accumulator.
// master = requester and result consumer, slave = the accumulator.
interface addsub_accumulator_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [N-1:0] in_data;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] acc;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic         flag_n;
    logic         ovf_sticky;

    modport master (
        output in_valid,
        output in_op,
        output in_data,
        output sat_en,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc,
        input  flag_c,
        input  flag_v,
        input  flag_z,
        input  flag_n,
        input  ovf_sticky
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_data,
        input  sat_en,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc,
        output flag_c,
        output flag_v,
        output flag_z,
        output flag_n,
        output ovf_sticky
    );
endinterface

// File: rtl/addsub_accumulator.sv
// N-bit add/subtract accumulator with saturation and status flags.
// One operation in flight; result held until the consumer accepts it.
module addsub_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         add_n,
    output logic [N-1:0] z,
    output logic         c_out,
    output logic         v
);
    logic [N-1:0] y_eff;
    logic [N:0]   sum;

    assign y_eff = add_n ? ~y : y;
    assign sum   = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, add_n};
    assign z     = sum[N-1:0];
    assign c_out = sum[N];
    assign v     = (x[N-1] == y_eff[N-1]) && (sum[N-1] != x[N-1]);
endmodule

module addsub_accumulator #(
    parameter int N = 4
) (
    input logic                clk,
    input logic                rst,
    addsub_accumulator_if.slave bus
);
    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t state_q;
    state_t state_d;
    logic   ready;
    logic   valid;
    logic   accept;

    logic [N-1:0] acc_q, acc_d;
    logic         c_q, c_d;
    logic         v_q, v_d;
    logic         z_q, z_d;
    logic         n_q, n_d;
    logic         sticky_q, sticky_d;

    logic         is_load;
    logic         is_add;
    logic         is_sub;
    logic         is_clr;
    logic [N-1:0] sum;
    logic         c_raw;
    logic         v_raw;
    logic [N-1:0] sat_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign accept = ready && bus.in_valid;

    assign is_load = (bus.in_op == OP_LOAD);
    assign is_add  = (bus.in_op == OP_ADD);
    assign is_sub  = (bus.in_op == OP_SUB);
    assign is_clr  = (bus.in_op == OP_CLR);

    addsub_n #(
        .N(N)
    ) u_addsub (
        .x    (acc_q),
        .y    (bus.in_data),
        .add_n(is_sub),
        .z    (sum),
        .c_out(c_raw),
        .v    (v_raw)
    );

    // Overflow direction always follows the accumulator's sign
    assign sat_val = acc_q[N-1] ? {1'b1, {(N-1){1'b0}}}
                                : {1'b0, {(N-1){1'b1}}};

    always_comb begin
        acc_d    = acc_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        sticky_d = sticky_q;
        if (accept) begin
            unique case (1'b1)
                is_load: begin
                    acc_d = bus.in_data;
                    c_d   = 1'b0;
                    v_d   = 1'b0;
                end
                is_add, is_sub: begin
                    c_d   = c_raw;
                    v_d   = v_raw;
                    acc_d = (bus.sat_en && v_raw) ? sat_val : sum;
                    if (v_raw) begin
                        sticky_d = 1'b1;
                    end
                end
                is_clr: begin
                    acc_d    = '0;
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    sticky_d = 1'b0;
                end
            endcase
            z_d = (acc_d == '0);
            n_d = acc_d[N-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid;
    assign bus.acc        = acc_q;
    assign bus.flag_c     = c_q;
    assign bus.flag_v     = v_q;
    assign bus.flag_z     = z_q;
    assign bus.flag_n     = n_q;
    assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: directed cases with literal
// expectations plus randomized traffic against an arithmetic reference model.
module tb_addsub_accumulator;
    localparam int N    = 4;
    localparam int MOD  = 1 << N;
    localparam int HALF = 1 << (N - 1);
    localparam int MAXP = HALF - 1;
    localparam int MINN = -HALF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    addsub_accumulator_if #(.N(N)) bus ();

    addsub_accumulator #(
        .N(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [N-1:0] acc;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        logic         s;
    } mstate_t;

    mstate_t m;
    bit      m_busy;

    function automatic mstate_t model_op(mstate_t cur, logic [1:0] op,
                                         logic [N-1:0] d, logic sat);
        mstate_t nx = cur;
        int a  = int'(cur.acc);
        int b  = int'(d);
        int sa = (a >= HALF) ? a - MOD : a;
        int sb = (b >= HALF) ? b - MOD : b;
        int r  = 0;
        case (op)
            2'd0: begin
                nx.acc = d;
                nx.c   = 1'b0;
                nx.v   = 1'b0;
            end
            2'd1: begin
                nx.c = (a + b) >= MOD;
                r    = sa + sb;
            end
            2'd2: begin
                nx.c = (a >= b);
                r    = sa - sb;
            end
            default: begin
                nx.acc = '0;
                nx.c   = 1'b0;
                nx.v   = 1'b0;
                nx.s   = 1'b0;
            end
        endcase
        if (op == 2'd1 || op == 2'd2) begin
            nx.v = (r > MAXP) || (r < MINN);
            if (nx.v && sat) begin
                nx.acc = (r > MAXP) ? N'(MAXP) : N'(MINN);
            end else begin
                nx.acc = N'(r);
            end
            if (nx.v) nx.s = 1'b1;
        end
        nx.z = (nx.acc == '0);
        nx.n = nx.acc[N-1];
        return nx;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m      <= '0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (bus.out_ready) m_busy <= 1'b0;
        end else if (bus.in_valid) begin
            m      <= model_op(m, bus.in_op, bus.in_data, bus.sat_en);
            m_busy <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_in_ready", 32'(bus.in_ready), 32'(!m_busy));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_busy));
            chk("m_acc", 32'(bus.acc), 32'(m.acc));
            chk("m_flag_c", 32'(bus.flag_c), 32'(m.c));
            chk("m_flag_v", 32'(bus.flag_v), 32'(m.v));
            chk("m_flag_z", 32'(bus.flag_z), 32'(m.z));
            chk("m_flag_n", 32'(bus.flag_n), 32'(m.n));
            chk("m_sticky", 32'(bus.ovf_sticky), 32'(m.s));
        end
    end

    task automatic expect_out(input string tag, input int a, input bit c,
                              input bit v, input bit z, input bit n,
                              input bit s, input bit ov);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, "_acc"}, 32'(bus.acc), 32'(a));
        chk({tag, "_c"}, 32'(bus.flag_c), 32'(c));
        chk({tag, "_v"}, 32'(bus.flag_v), 32'(v));
        chk({tag, "_z"}, 32'(bus.flag_z), 32'(z));
        chk({tag, "_n"}, 32'(bus.flag_n), 32'(n));
        chk({tag, "_sticky"}, 32'(bus.ovf_sticky), 32'(s));
    endtask

    // Issue one operation from IDLE; returns with the result presented.
    task automatic do_op(input logic [1:0] op, input logic [N-1:0] d,
                         input logic sat);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_in_ready actual=0 required=1");
        end
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_data   = d;
        bus.sat_en    = sat;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_data   = '0;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        do_op(2'd0, 4'd5, 1'b0);
        expect_out("load5", 5, 0, 0, 0, 0, 0, 1);
        release_out();
        do_op(2'd1, 4'd3, 1'b0);
        expect_out("add3_wrap", 8, 0, 1, 0, 1, 1, 1);
        release_out();

        do_op(2'd1, 4'd1, 1'b0);
        expect_out("sticky_hold", 9, 0, 0, 0, 1, 1, 1);
        release_out();
        do_op(2'd3, 4'd9, 1'b0);
        expect_out("clear", 0, 0, 0, 1, 0, 0, 1);
        release_out();

        do_op(2'd0, 4'd5, 1'b1);
        release_out();
        do_op(2'd1, 4'd3, 1'b1);
        expect_out("sat_pos", 7, 0, 1, 0, 0, 1, 1);
        release_out();
        do_op(2'd0, 4'd8, 1'b1);
        release_out();
        do_op(2'd2, 4'd1, 1'b1);
        expect_out("sat_neg", 8, 1, 1, 0, 1, 1, 1);
        release_out();

        do_op(2'd3, 4'd0, 1'b0);
        release_out();
        do_op(2'd0, 4'd3, 1'b0);
        release_out();
        do_op(2'd2, 4'd5, 1'b0);
        expect_out("sub_borrow", 14, 0, 0, 0, 1, 0, 1);
        release_out();
        do_op(2'd0, 4'd5, 1'b0);
        release_out();
        do_op(2'd2, 4'd5, 1'b0);
        expect_out("sub_zero", 0, 1, 0, 1, 0, 0, 1);
        release_out();

        do_op(2'd1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.in_op    = 2'd0;
                bus.in_data  = 4'hF;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            expect_out("bp_hold", 2, 0, 0, 0, 0, 0, 1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        release_out();
        chk("bp_idle", 32'(bus.out_valid), 32'd0);

        do_op(2'd0, 4'd8, 1'b0);
        release_out();
        do_op(2'd2, 4'd2, 1'b0);
        expect_out("pre_rst", 6, 1, 1, 0, 0, 1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out("rst_resp", 0, 0, 0, 0, 0, 0, 0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_op     = 2'($urandom);
            bus.in_data   = N'($urandom);
            bus.sat_en    = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
